// File: rtl/apa102_frame_rx.sv
// APA102 two-wire stream receiver: oversamples sclk/sdata, locks on the all-zero
// start frame and decodes 32-bit LED words into brightness/B/G/R with a pixel index.
module apa102_frame_rx #(
    parameter int NUM_LEDS = 64,
    parameter int IDX_W    = 6,
    parameter int TIMEOUT  = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_in,
    input  logic             sdata_in,
    output logic             pix_valid,
    output logic [IDX_W-1:0] pix_idx,
    output logic [4:0]       pix_bright,
    output logic [7:0]       pix_b,
    output logic [7:0]       pix_g,
    output logic [7:0]       pix_r,
    output logic             frame_done,
    output logic             hdr_err,
    output logic             frame_err,
    output logic             locked
);

    localparam int                 TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_LEDS - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic {
        HUNT = 1'b0,
        WORD = 1'b1
    } state_t;

    // Input conditioning
    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_sdata_s1, r_sdata_s2;

    // Receiver state
    state_t           r_state;
    logic [4:0]       r_zero_cnt;
    logic [4:0]       r_bit_cnt;
    logic [30:0]      r_shift;
    logic [IDX_W-1:0] r_idx;
    logic [TMO_W-1:0] r_tmo;

    // Registered outputs
    logic             r_pix_valid;
    logic [IDX_W-1:0] r_pix_idx;
    logic [4:0]       r_pix_bright;
    logic [7:0]       r_pix_b, r_pix_g, r_pix_r;
    logic             r_frame_done, r_hdr_err, r_frame_err;

    // Next-state values
    state_t           w_state_nx;
    logic [4:0]       w_zero_nx;
    logic [4:0]       w_bit_nx;
    logic [30:0]      w_shift_nx;
    logic [IDX_W-1:0] w_idx_nx;
    logic [TMO_W-1:0] w_tmo_nx;
    logic             w_valid_nx, w_done_nx, w_hdr_nx, w_ferr_nx;

    logic             w_rise;
    logic             w_bit;
    logic [31:0]      w_word;

    // The third sclk flop gives a one-clk rising-edge strobe aligned with sdata s2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_s1  <= 1'b0;
            r_sclk_s2  <= 1'b0;
            r_sclk_s3  <= 1'b0;
            r_sdata_s1 <= 1'b0;
            r_sdata_s2 <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples the previous-cycle value.
            r_sclk_s1  <= sclk_in;
            r_sclk_s2  <= r_sclk_s1;
            r_sclk_s3  <= r_sclk_s2;
            r_sdata_s1 <= sdata_in;
            r_sdata_s2 <= r_sdata_s1;
        end
    end

    assign w_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_bit  = r_sdata_s2;
    assign w_word = {r_shift, w_bit};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state_nx = r_state;
        w_zero_nx  = r_zero_cnt;
        w_bit_nx   = r_bit_cnt;
        w_shift_nx = r_shift;
        w_idx_nx   = r_idx;
        w_tmo_nx   = r_tmo;
        w_valid_nx = 1'b0;
        w_done_nx  = 1'b0;
        w_hdr_nx   = 1'b0;
        w_ferr_nx  = 1'b0;

        case (r_state)
            HUNT: begin
                w_tmo_nx = '0;
                if (w_rise) begin
                    if (w_bit) begin
                        w_zero_nx = '0;
                    end else if (r_zero_cnt == 5'd31) begin
                        w_state_nx = WORD;
                        w_zero_nx  = '0;
                        w_bit_nx   = '0;
                        w_idx_nx   = '0;
                    end else begin
                        w_zero_nx = r_zero_cnt + 5'd1;
                    end
                end
            end

            WORD: begin
                if (w_rise) begin
                    w_tmo_nx   = '0;
                    w_shift_nx = w_word[30:0];
                    if (r_bit_cnt == 5'd31) begin
                        w_bit_nx = '0;
                        if (w_word[31:29] == 3'b111) begin
                            w_valid_nx = 1'b1;
                            if (r_idx == LAST_IDX) begin
                                w_done_nx  = 1'b1;
                                w_state_nx = HUNT;
                                w_zero_nx  = '0;
                                w_idx_nx   = '0;
                            end else begin
                                w_idx_nx = r_idx + 1'b1;
                            end
                        end else if (w_word == '0) begin
                            // An all-zero word restarts the frame; only a restart mid-frame is an error.
                            w_ferr_nx = (r_idx != '0);
                            w_idx_nx  = '0;
                        end else begin
                            w_hdr_nx   = 1'b1;
                            w_state_nx = HUNT;
                            w_zero_nx  = '0;
                        end
                    end else begin
                        w_bit_nx = r_bit_cnt + 5'd1;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_ferr_nx  = (r_bit_cnt != '0) || (r_idx != '0);
                    w_state_nx = HUNT;
                    w_zero_nx  = '0;
                    w_bit_nx   = '0;
                    w_idx_nx   = '0;
                    w_tmo_nx   = '0;
                end else begin
                    w_tmo_nx = r_tmo + 1'b1;
                end
            end

            default: w_state_nx = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= HUNT;
            r_zero_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_tmo        <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_idx    <= '0;
            r_pix_bright <= '0;
            r_pix_b      <= '0;
            r_pix_g      <= '0;
            r_pix_r      <= '0;
            r_frame_done <= 1'b0;
            r_hdr_err    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_zero_cnt   <= w_zero_nx;
            r_bit_cnt    <= w_bit_nx;
            r_shift      <= w_shift_nx;
            r_idx        <= w_idx_nx;
            r_tmo        <= w_tmo_nx;
            r_pix_valid  <= w_valid_nx;
            r_frame_done <= w_done_nx;
            r_hdr_err    <= w_hdr_nx;
            r_frame_err  <= w_ferr_nx;
            if (w_valid_nx) begin
                r_pix_idx    <= r_idx;
                r_pix_bright <= w_word[28:24];
                r_pix_b      <= w_word[23:16];
                r_pix_g      <= w_word[15:8];
                r_pix_r      <= w_word[7:0];
            end
        end
    end

    assign pix_valid  = r_pix_valid;
    assign pix_idx    = r_pix_idx;
    assign pix_bright = r_pix_bright;
    assign pix_b      = r_pix_b;
    assign pix_g      = r_pix_g;
    assign pix_r      = r_pix_r;
    assign frame_done = r_frame_done;
    assign hdr_err    = r_hdr_err;
    assign frame_err  = r_frame_err;
    assign locked     = (r_state == WORD);

endmodule
